// File: rtl/wb_master_arbiter.sv
// Round-robin arbiter sharing one Wishbone master port between three requesters.
// Optional BUSY timeout abort is built when WB_ARB_TIMEOUT_EN is defined.
module wb_master_arbiter #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        PHY_CLK33_I,
    input  logic        PHY_RST_I,
    input  logic [31:0] M0_WB_ADD_I,
    input  logic [31:0] M0_WB_DATA_I,
    output logic [31:0] M0_WB_DATA_O,
    input  logic        M0_WB_STB_I,
    input  logic        M0_WB_WE_I,
    output logic        M0_WB_ACK_O,
    output logic        M0_WB_VALID_O,
    output logic        M0_WB_ERR_O,
    input  logic [31:0] M1_WB_ADD_I,
    input  logic [31:0] M1_WB_DATA_I,
    output logic [31:0] M1_WB_DATA_O,
    input  logic        M1_WB_STB_I,
    input  logic        M1_WB_WE_I,
    output logic        M1_WB_ACK_O,
    output logic        M1_WB_VALID_O,
    output logic        M1_WB_ERR_O,
    input  logic [31:0] M2_WB_ADD_I,
    input  logic [31:0] M2_WB_DATA_I,
    output logic [31:0] M2_WB_DATA_O,
    input  logic        M2_WB_STB_I,
    input  logic        M2_WB_WE_I,
    output logic        M2_WB_ACK_O,
    output logic        M2_WB_VALID_O,
    output logic        M2_WB_ERR_O,
    output logic [31:0] ARB_WB_ADD_O,
    output logic [31:0] ARB_WB_DATA_O,
    input  logic [31:0] ARB_WB_DATA_I,
    input  logic        ARB_WB_ACK_I,
    input  logic        ARB_WB_VALID_I,
    output logic        ARB_WB_STB_O,
    output logic        ARB_WB_WE_O,
    output logic [1:0]  ARB_GNT_O
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RELEASE} state_t;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 2..65535");
    end

    logic [31:0] w_add [3];
    logic [31:0] w_wdat [3];
    logic [2:0]  w_stb, w_we;

    assign w_add[0]  = M0_WB_ADD_I;
    assign w_add[1]  = M1_WB_ADD_I;
    assign w_add[2]  = M2_WB_ADD_I;
    assign w_wdat[0] = M0_WB_DATA_I;
    assign w_wdat[1] = M1_WB_DATA_I;
    assign w_wdat[2] = M2_WB_DATA_I;
    assign w_stb     = {M2_WB_STB_I, M1_WB_STB_I, M0_WB_STB_I};
    assign w_we      = {M2_WB_WE_I, M1_WB_WE_I, M0_WB_WE_I};

    state_t      r_state, w_state_nxt;
    logic [1:0]  r_gnt, w_gnt_nxt, r_last, w_last_nxt, w_pick;
    logic [31:0] r_arb_add, w_arb_add_nxt, r_arb_dat, w_arb_dat_nxt;
    logic        r_arb_stb, w_arb_stb_nxt, r_arb_we, w_arb_we_nxt;
    logic [2:0]  r_ack, w_ack_nxt, r_vld, w_vld_nxt;
    logic [31:0] r_rdat [3];
    logic [31:0] w_rdat_nxt [3];
    logic        w_win_stb, w_timeout;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]       r_err, w_err_nxt;
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // First requesting master after the last owner, wrapping 2 -> 0.
    function automatic logic [1:0] pick(input logic [1:0] last, input logic [2:0] stb);
        int   idx;
        logic found;
        pick  = 2'd3;
        found = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            idx = (int'(last) + i) % 3;
            if (!found && stb[idx]) begin
                pick  = 2'(idx);
                found = 1'b1;
            end
        end
    endfunction

    assign w_pick = pick(r_last, w_stb);

    always_comb begin
        w_win_stb = 1'b0;
        for (int n = 0; n < 3; n++)
            if (r_gnt == 2'(n)) w_win_stb = w_stb[n];
    end

    always_ff @(posedge PHY_CLK33_I or posedge PHY_RST_I) begin
        if (PHY_RST_I) begin
            r_state   <= S_IDLE;
            r_gnt     <= 2'd3;
            r_last    <= 2'd2;
            r_arb_add <= '0;
            r_arb_dat <= '0;
            r_arb_stb <= 1'b0;
            r_arb_we  <= 1'b0;
            r_ack     <= '0;
            r_vld     <= '0;
            for (int n = 0; n < 3; n++) r_rdat[n] <= '0;
`ifdef WB_ARB_TIMEOUT_EN
            r_cnt     <= '0;
            r_err     <= '0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_last    <= w_last_nxt;
            r_arb_add <= w_arb_add_nxt;
            r_arb_dat <= w_arb_dat_nxt;
            r_arb_stb <= w_arb_stb_nxt;
            r_arb_we  <= w_arb_we_nxt;
            r_ack     <= w_ack_nxt;
            r_vld     <= w_vld_nxt;
            for (int n = 0; n < 3; n++) r_rdat[n] <= w_rdat_nxt[n];
`ifdef WB_ARB_TIMEOUT_EN
            r_cnt     <= w_cnt_nxt;
            r_err     <= w_err_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (|w_stb) w_state_nxt = S_BUSY;
            S_BUSY:    if (ARB_WB_ACK_I || !w_win_stb || w_timeout) w_state_nxt = S_RELEASE;
            S_RELEASE: if (!w_win_stb && !ARB_WB_ACK_I) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_gnt_nxt     = r_gnt;
        w_last_nxt    = r_last;
        w_arb_add_nxt = r_arb_add;
        w_arb_dat_nxt = r_arb_dat;
        w_arb_stb_nxt = r_arb_stb;
        w_arb_we_nxt  = r_arb_we;
        w_ack_nxt     = '0;
        w_vld_nxt     = '0;
        for (int n = 0; n < 3; n++) w_rdat_nxt[n] = r_rdat[n];
`ifdef WB_ARB_TIMEOUT_EN
        w_cnt_nxt     = r_cnt;
        w_err_nxt     = '0;
`endif
        case (r_state)
            S_IDLE: begin
`ifdef WB_ARB_TIMEOUT_EN
                w_cnt_nxt = '0;
`endif
                if (|w_stb) begin
                    w_gnt_nxt     = w_pick;
                    w_arb_stb_nxt = 1'b1;
                    for (int n = 0; n < 3; n++)
                        if (w_pick == 2'(n)) begin
                            w_arb_add_nxt = w_add[n];
                            w_arb_dat_nxt = w_wdat[n];
                            w_arb_we_nxt  = w_we[n];
                        end
                end
            end
            S_BUSY: begin
                // ACK outranks both an abort and a timeout in the same cycle.
                if (ARB_WB_ACK_I) begin
                    w_arb_stb_nxt = 1'b0;
                    for (int n = 0; n < 3; n++)
                        if (r_gnt == 2'(n)) begin
                            w_ack_nxt[n]  = 1'b1;
                            w_vld_nxt[n]  = ARB_WB_VALID_I;
                            w_rdat_nxt[n] = ARB_WB_DATA_I;
                        end
                end else if (!w_win_stb) begin
                    w_arb_stb_nxt = 1'b0;
                end else if (w_timeout) begin
                    w_arb_stb_nxt = 1'b0;
                    for (int n = 0; n < 3; n++)
                        if (r_gnt == 2'(n)) begin
                            w_ack_nxt[n]  = 1'b1;
                            w_rdat_nxt[n] = 32'hFFFF_FFFF;
`ifdef WB_ARB_TIMEOUT_EN
                            w_err_nxt[n]  = 1'b1;
`endif
                        end
                end else begin
`ifdef WB_ARB_TIMEOUT_EN
                    if (r_cnt != {CNT_W{1'b1}}) w_cnt_nxt = r_cnt + 1'b1;
`endif
                end
            end
            S_RELEASE: begin
                if (!w_win_stb && !ARB_WB_ACK_I) begin
                    w_last_nxt = r_gnt;
                    w_gnt_nxt  = 2'd3;
                end
            end
            default: w_gnt_nxt = 2'd3;
        endcase
    end

    assign ARB_WB_ADD_O  = r_arb_add;
    assign ARB_WB_DATA_O = r_arb_dat;
    assign ARB_WB_STB_O  = r_arb_stb;
    assign ARB_WB_WE_O   = r_arb_we;
    assign ARB_GNT_O     = r_gnt;
    assign M0_WB_ACK_O   = r_ack[0];
    assign M1_WB_ACK_O   = r_ack[1];
    assign M2_WB_ACK_O   = r_ack[2];
    assign M0_WB_VALID_O = r_vld[0];
    assign M1_WB_VALID_O = r_vld[1];
    assign M2_WB_VALID_O = r_vld[2];
    assign M0_WB_DATA_O  = r_rdat[0];
    assign M1_WB_DATA_O  = r_rdat[1];
    assign M2_WB_DATA_O  = r_rdat[2];
`ifdef WB_ARB_TIMEOUT_EN
    assign M0_WB_ERR_O   = r_err[0];
    assign M1_WB_ERR_O   = r_err[1];
    assign M2_WB_ERR_O   = r_err[2];
`else
    assign M0_WB_ERR_O   = 1'b0;
    assign M1_WB_ERR_O   = 1'b0;
    assign M2_WB_ERR_O   = 1'b0;
`endif
endmodule

// File: doc/wb_master_arbiter.md
Name: wb_master_arbiter

Overview:
- Shares the single Wishbone master port of the internal interconnect between three requesters: PCI target path, DMA engine and config/debug engine.
- Round-robin arbitration with one transaction per grant.
- Latches the winner's address, data and WE, drives the interconnect master port, and returns ACK, VALID and read data to the winner only.
- Sits between the requesters and the interconnect's M0 port, in the PHY_CLK33_I domain.

Parameters:
- TIMEOUT_CYCLES, 256: cycles the arbiter waits in BUSY for ARB_WB_ACK_I before aborting. Range 2..65535. Only used with WB_ARB_TIMEOUT_EN.

Ports:
- PHY_CLK33_I  in  1  33 MHz clock; all logic on rising edge.
- PHY_RST_I  in  1  asynchronous, active-high reset.
- Mn_WB_ADD_I  in  32  requester n address, for n = 0..2 (same for all Mn ports below).
- Mn_WB_DATA_I  in  32  requester n write data.
- Mn_WB_DATA_O  out  32  read data to requester n.
- Mn_WB_STB_I  in  1  request strobe; held high until ACK seen.
- Mn_WB_WE_I  in  1  1 = write.
- Mn_WB_ACK_O  out  1  one-cycle completion pulse.
- Mn_WB_VALID_O  out  1  read data valid; qualifies Mn_WB_ACK_O.
- Mn_WB_ERR_O  out  1  one-cycle timeout error pulse, coincident with ACK.
- ARB_WB_ADD_O  out  32  address to interconnect M0.
- ARB_WB_DATA_O  out  32  write data to interconnect.
- ARB_WB_DATA_I  in  32  read data from interconnect.
- ARB_WB_ACK_I  in  1  ack from interconnect.
- ARB_WB_VALID_I  in  1  valid from interconnect.
- ARB_WB_STB_O  out  1  strobe to interconnect.
- ARB_WB_WE_O  out  1  write enable to interconnect.
- ARB_GNT_O  out  2  current owner: 0..2, or 3 = none (debug).

Behaviour:
- Reset: all outputs 0 except ARB_GNT_O = 3. State = IDLE, last-grant pointer = 2 (so M0 wins first), timeout counter = 0. Reset mid-transaction drops ARB_WB_STB_O immediately and asynchronously; no ACK is issued.
- States: IDLE, BUSY, RELEASE. All outputs are registered.
- IDLE, no STB_I high: stay in IDLE, ARB_GNT_O = 3.
- IDLE, any STB_I high:
  - Winner = first requester with STB_I high, searching from (last+1) mod 3 upward with wrap.
  - On the next edge: latch the winner's ADD/DATA/WE onto ARB_WB_*_O, set ARB_WB_STB_O = 1, ARB_GNT_O = winner, counter = 0, go to BUSY.
  - Latency: STB_I sampled high at edge k gives ARB_WB_STB_O high after edge k.
- BUSY: ARB outputs are held constant. Input changes on the winner are ignored except STB.
- BUSY, ARB_WB_ACK_I = 1:
  - Next edge: Mn_WB_ACK_O = 1 and Mn_WB_VALID_O = ARB_WB_VALID_I for the winner only.
  - Mn_WB_DATA_O = ARB_WB_DATA_I (winner only; other DATA_O hold their value).
  - ARB_WB_STB_O = 0; go to RELEASE.
- BUSY, winner drops STB_I before ACK (abort): ARB_WB_STB_O = 0, no ACK to the winner, go to RELEASE.
- BUSY, ACK and STB drop in the same cycle: ACK takes priority, and ACK is issued.
- RELEASE:
  - ACK, VALID and ERR outputs return to 0 after exactly one cycle.
  - Stay until the winner's STB_I = 0 AND ARB_WB_ACK_I = 0. This lets the interconnect clear its registered ACK.
  - Then last = winner, ARB_GNT_O = 3, go to IDLE.
  - The minimum turnaround between grants is therefore one IDLE cycle.
- Fairness: a requester that keeps STB_I asserted across grants gets at most one transaction per round while others are pending. Non-winners never see ACK, VALID, ERR or a DATA_O update.
- Counter: $clog2(TIMEOUT_CYCLES+1) bits, saturating, and reset in IDLE.

Optional Feature:
- WB_ARB_TIMEOUT_EN defined:
  - In BUSY the counter increments each cycle without ACK.
  - When it reaches TIMEOUT_CYCLES-1 with ARB_WB_ACK_I still 0, the next edge gives: winner Mn_WB_ACK_O = 1, Mn_WB_ERR_O = 1, Mn_WB_VALID_O = 0, Mn_WB_DATA_O = 32'hFFFF_FFFF, ARB_WB_STB_O = 0, go to RELEASE.
  - If ACK arrives in the same cycle the counter reaches the limit, ACK wins.
- WB_ARB_TIMEOUT_EN undefined:
  - No counter is built; BUSY waits indefinitely.
  - All Mn_WB_ERR_O are tied 0.

Test Plan:
- Single read: M0 STB=1, ADD=32'h0000_1004, WE=0; slave returns ACK/VALID with DATA=32'hCAFE_0001 → ARB_WB_ADD_O=32'h0000_1004 one cycle after STB; M0 ACK=1, VALID=1, DATA_O=32'hCAFE_0001 for one cycle; M1/M2 ACK stay 0.
- Round-robin: M0, M1 and M2 all hold STB with continuous requests → grant order 0,1,2,0,1,2 on ARB_GNT_O; no requester is granted twice in a row while others are pending.
- Write passthrough: M2 write ADD=32'h0000_2000, DATA=32'h1234_5678 while M0 asserts STB mid-transaction → ARB outputs stay on M2 values until ACK; M0 granted only after M2 drops STB and ARB_WB_ACK_I is 0.
- Abort: M1 drops STB two cycles into BUSY → ARB_WB_STB_O falls next edge; no M1 ACK; arbiter returns to IDLE.
- Timeout (WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): M0 read, slave never ACKs → M0 ACK=1 and ERR=1 with DATA_O=32'hFFFF_FFFF eight cycles after STB_O rose; without the macro, STB_O stays high for 100+ cycles and ERR stays 0.
- Async reset: assert PHY_RST_I mid-BUSY between clock edges → ARB_WB_STB_O=0 and ARB_GNT_O=3 immediately; after release, M0 wins the first grant.
